hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- Architectural HI/LO register block, directly downstream of the multiplier.
- Sequences a multiply: pulses the multiplier's write enable, waits the multiplier latency, then captures its hi/lo outputs into HI/LO.
- Services MFHI/MFLO reads and MTHI/MTLO writes, and raises stall to decode while a multiply is in flight.

Parameters:
- width, 32, data width of HI, LO and all data ports.
- LATENCY, 1, cycles from the multiplier-sampling edge to valid mul_hi/mul_lo (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- mul_start  input  1  decode requests a multiply; operands are already presented on the multiplier inputs
- mul_we  output  1  write enable to the multiplier
- mul_hi  input  width  upper product half from the multiplier
- mul_lo  input  width  lower product half from the multiplier
- mf_req  input  1  move-from request
- mf_sel  input  1  move-from select: 0=LO, 1=HI
- mf_data  output  width  move-from data
- mf_valid  output  1  mf_data is valid this cycle
- mt_we  input  1  move-to write enable
- mt_sel  input  1  move-to select: 0=LO, 1=HI
- mt_data  input  width  move-to write data
- busy  output  1  multiply in flight
- stall  output  1  decode must hold its current request
- mul_done  output  1  one-cycle pulse on the cycle after HI/LO capture
- hi  output  width  architectural HI
- lo  output  width  architectural LO

Behaviour:
Reset:
- rst_n low asynchronously forces state=IDLE, cnt=0, hi=0, lo=0, mul_done=0.
- Combinational outputs follow from reset state: busy=0, stall=0, mul_we=0, mf_valid=0.

FSM states:
- IDLE: mul_we = mul_start (combinational), so the multiplier samples at the edge ending the start cycle. On that edge with mul_start=1: go to WAIT, cnt<=LATENCY-1.
- WAIT: busy=1, mul_we=0.
  - cnt!=0: cnt<=cnt-1 each edge.
  - cnt==0: at that edge, {hi,lo}<={mul_hi,mul_lo}, mul_done<=1 (next cycle only), go to IDLE.
- Total: with LATENCY=L, HI/LO update L+1 edges after the start-cycle edge is sampled. Default: start in cycle 0, capture at end of cycle 1, new hi/lo visible in cycle 2.

Stall and request handling:
- stall = busy & (mul_start | mf_req | mt_we).
- Stalled requests have no effect; decode re-presents them until stall=0.
- mul_start during WAIT never re-asserts mul_we.

Move-from:
- mf_valid = mf_req & ~busy.
- mf_data = mf_sel ? hi : lo, taken from the registers, with no bypass.
- mf_data is don't-care when mf_valid=0; drive 0.

Move-to:
- mt_we in IDLE writes mt_data into HI or LO, per mt_sel, at the edge.
- mt_we with mf_req in the same cycle: mf returns the old value.
- mt_we with mul_start in the same cycle: both accepted. The mt write lands now; the multiply result later overwrites both HI and LO.

Width and latency:
- No arithmetic beyond the counter. cnt is 4 bits.
- LATENCY=1 loads cnt=0, giving exactly one WAIT cycle.

Reset mid-operation:
- WAIT aborts to IDLE with hi=lo=0.
- The multiplier's pending internal result is discarded and never captured.
- mul_done stays 0.

Back-to-back multiplies:
- mul_start held through WAIT is accepted on the first IDLE cycle, i.e. the cycle mul_done=1.
- Throughput: one multiply per LATENCY+1 cycles.

Test Plan:
- Reset → all outputs 0; then mt_we=1, mt_sel=1, mt_data=0xDEADBEEF → next cycle hi=0xDEADBEEF, lo=0.
- Multiplier instanced (width 32, LATENCY=1), A=0x00010000, B=0x00010000, mul_start pulsed in cycle 0 → mul_we=1 in cycle 0 only; busy=1 in cycle 1; hi=0x00000001, lo=0x00000000 and mul_done=1 in cycle 2.
- Multiply A=0xFFFFFFFF, B=0x00000002 with mf_req=1, mf_sel=0 held from cycle 1 → stall=1 and mf_valid=0 in cycle 1; cycle 2: mf_valid=1, mf_data=0xFFFFFFFE; hi=0x00000001.
- LATENCY=3 with a multiplier model delaying outputs 3 cycles, A=7, B=6 → busy high for exactly 3 cycles; lo=42 visible 4 cycles after the start cycle; no capture of stale values earlier.
- rst_n dropped asynchronously mid-WAIT of a multiply with A=5, B=5 → immediate busy=0, hi=lo=0; after release, lo stays 0 and mul_done never pulses.
- Same cycle mt_we (LO←0x12345678) and mul_start (A=3, B=3) in IDLE → lo=0x12345678 for one cycle, then lo=9 and hi=0 after capture; a second mul_start held during WAIT issues mul_we on the mul_done cycle.

Source files
------------

// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO register pair sitting behind the multiplier.
// It launches a multiply, waits out the multiplier latency, captures the
// product into HI/LO, serves move-from/move-to accesses, and stalls decode
// while a multiply is in flight.
//
// Handshake: decode holds a request (mul_start, mf_req, mt_we) steady until
// a cycle in which stall=0; the request takes effect in that cycle (at its
// closing edge for writes, combinationally for mf_data/mf_valid). A request
// presented while stall=1 has no effect at all.
module hilo_unit #(
    parameter int width   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mul_start,
    output logic             mul_we,
    input  logic [width-1:0] mul_hi,
    input  logic [width-1:0] mul_lo,
    input  logic             mf_req,
    input  logic             mf_sel,
    output logic [width-1:0] mf_data,
    output logic             mf_valid,
    input  logic             mt_we,
    input  logic             mt_sel,
    input  logic [width-1:0] mt_data,
    output logic             busy,
    output logic             stall,
    output logic             mul_done,
    output logic [width-1:0] hi,
    output logic [width-1:0] lo
);

    // Counter load value: LATENCY=1 loads 0, giving a single WAIT cycle.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    // IDLE: accepting requests. WAIT: multiplier result not yet valid.
    // The state signal is left visible at this level for checker binding.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic       capture;

    // State and latency counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic: start launches WAIT, counter expiry returns to IDLE.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (mul_start) begin
                    state_nx = WAIT;
                    cnt_nx   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Output logic: everything decode and the multiplier see is combinational.
    always_comb begin
        busy     = (state == WAIT);
        capture  = (state == WAIT) && (cnt == 4'd0);
        mul_we   = (state == IDLE) && mul_start;
        stall    = busy && (mul_start || mf_req || mt_we);
        mf_valid = mf_req && !busy;
        mf_data  = '0;
        if (mf_valid) begin
            mf_data = mf_sel ? hi : lo;
        end
    end

    // HI/LO registers: product capture wins over a move-to; move-to only in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            mul_done <= 1'b0;
        end else begin
            mul_done <= capture;
            if (capture) begin
                hi <= mul_hi;
                lo <= mul_lo;
            end else if (mt_we && (state == IDLE)) begin
                if (mt_sel) begin
                    hi <= mt_data;
                end else begin
                    lo <= mt_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: one instance at LATENCY=1 and one at
// LATENCY=3, each fed by its own behavioural multiplier model that shows a
// junk pattern whenever its result is not the freshly sampled product.
module tb_hilo_unit;

    localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic        mul_start = 1'b0;
    logic        mf_req = 1'b0;
    logic        mf_sel = 1'b0;
    logic        mt_we = 1'b0;
    logic        mt_sel = 1'b0;
    logic [31:0] mt_data = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [63:0] prod;
    assign prod = {32'd0, op_a} * {32'd0, op_b};

    // ---------------- LATENCY=1 instance ----------------
    logic        we1, mf_valid1, busy1, stall1, done1;
    logic [31:0] mf_data1, hi1, lo1;
    logic [63:0] p1;
    always @(posedge clk) p1 <= we1 ? prod : JUNK;

    hilo_unit #(.width(32), .LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .mul_start(mul_start), .mul_we(we1),
        .mul_hi(p1[63:32]), .mul_lo(p1[31:0]),
        .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data1), .mf_valid(mf_valid1),
        .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data),
        .busy(busy1), .stall(stall1), .mul_done(done1), .hi(hi1), .lo(lo1)
    );

    // ---------------- LATENCY=3 instance ----------------
    logic        we3, mf_valid3, busy3, stall3, done3;
    logic [31:0] mf_data3, hi3, lo3;
    logic [63:0] p3 [3];
    always @(posedge clk) begin
        p3[0] <= we3 ? prod : JUNK;
        p3[1] <= JUNK ^ 64'h1;
        p3[2] <= p3[1];
        if (p3[0] != JUNK) p3[1] <= p3[0];
    end

    hilo_unit #(.width(32), .LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n), .mul_start(mul_start), .mul_we(we3),
        .mul_hi(p3[2][63:32]), .mul_lo(p3[2][31:0]),
        .mf_req(mf_req), .mf_sel(mf_sel), .mf_data(mf_data3), .mf_valid(mf_valid3),
        .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data),
        .busy(busy3), .stall(stall3), .mul_done(done3), .hi(hi3), .lo(lo3)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge; checks happen at
    // the falling edge of the same cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mul_start = 1'b0;
        mf_req    = 1'b0;
        mf_sel    = 1'b0;
        mt_we     = 1'b0;
        mt_sel    = 1'b0;
        mt_data   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    // ---------------- move-to / move-from vector table ----------------
    typedef struct {
        logic        mt_we;
        logic        mt_sel;
        logic [31:0] mt_data;
        logic        mf_req;
        logic        mf_sel;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // expected hi/lo are the register values during the vector's cycle
        vecs[0] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0BADF00D, 1'b1, 1'b0, 1'b1, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0BADF00D, 32'hDEADBEEF, 32'h0BADF00D};
        vecs[4] = '{1'b1, 1'b1, 32'h11111111, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0BADF00D};
        vecs[5] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h11111111, 32'h11111111, 32'h0BADF00D};

        do_reset();
        sample();
        chk("rst busy", {63'd0, busy1}, 64'd0);
        chk("rst stall", {63'd0, stall1}, 64'd0);
        chk("rst mul_we", {63'd0, we1}, 64'd0);
        chk("rst mf_valid", {63'd0, mf_valid1}, 64'd0);
        chk("rst mul_done", {63'd0, done1}, 64'd0);
        chk("rst hi", {32'd0, hi1}, 64'd0);
        chk("rst lo", {32'd0, lo1}, 64'd0);
        chk("rst mf_data", {32'd0, mf_data1}, 64'd0);
        next_cycle();

        // table-driven IDLE move-to / move-from
        for (int i = 0; i < 6; i++) begin
            mt_we   = vecs[i].mt_we;
            mt_sel  = vecs[i].mt_sel;
            mt_data = vecs[i].mt_data;
            mf_req  = vecs[i].mf_req;
            mf_sel  = vecs[i].mf_sel;
            sample();
            chk($sformatf("vec%0d mf_valid", i), {63'd0, mf_valid1}, {63'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d mf_data", i), {32'd0, mf_data1}, {32'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d hi", i), {32'd0, hi1}, {32'd0, vecs[i].exp_hi});
            chk($sformatf("vec%0d lo", i), {32'd0, lo1}, {32'd0, vecs[i].exp_lo});
            next_cycle();
        end
        idle_inputs();

        // multiply 0x10000 * 0x10000 at LATENCY=1
        op_a = 32'h00010000;
        op_b = 32'h00010000;
        mul_start = 1'b1;
        sample();
        chk("mulA c0 mul_we", {63'd0, we1}, 64'd1);
        chk("mulA c0 busy", {63'd0, busy1}, 64'd0);
        next_cycle();
        mul_start = 1'b0;
        sample();
        chk("mulA c1 mul_we", {63'd0, we1}, 64'd0);
        chk("mulA c1 busy", {63'd0, busy1}, 64'd1);
        chk("mulA c1 stall", {63'd0, stall1}, 64'd0);
        next_cycle();
        sample();
        chk("mulA c2 hi", {32'd0, hi1}, 64'h1);
        chk("mulA c2 lo", {32'd0, lo1}, 64'h0);
        chk("mulA c2 mul_done", {63'd0, done1}, 64'd1);
        chk("mulA c2 busy", {63'd0, busy1}, 64'd0);
        next_cycle();
        sample();
        chk("mulA c3 mul_done", {63'd0, done1}, 64'd0);
        next_cycle();

        // multiply 0xFFFFFFFF * 2 with a move-from LO held from cycle 1
        op_a = 32'hFFFFFFFF;
        op_b = 32'h00000002;
        mul_start = 1'b1;
        next_cycle();
        mul_start = 1'b0;
        mf_req = 1'b1;
        mf_sel = 1'b0;
        sample();
        chk("mulB c1 stall", {63'd0, stall1}, 64'd1);
        chk("mulB c1 mf_valid", {63'd0, mf_valid1}, 64'd0);
        chk("mulB c1 mf_data", {32'd0, mf_data1}, 64'd0);
        next_cycle();
        sample();
        chk("mulB c2 mf_valid", {63'd0, mf_valid1}, 64'd1);
        chk("mulB c2 mf_data", {32'd0, mf_data1}, 64'hFFFFFFFE);
        chk("mulB c2 hi", {32'd0, hi1}, 64'h1);
        chk("mulB c2 stall", {63'd0, stall1}, 64'd0);
        next_cycle();
        idle_inputs();

        // LATENCY=3: 7 * 6, busy for exactly three cycles
        do_reset();
        op_a = 32'd7;
        op_b = 32'd6;
        mul_start = 1'b1;
        sample();
        chk("lat3 c0 mul_we", {63'd0, we3}, 64'd1);
        next_cycle();
        mul_start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            sample();
            chk($sformatf("lat3 c%0d busy", c), {63'd0, busy3}, 64'd1);
            chk($sformatf("lat3 c%0d lo", c), {32'd0, lo3}, 64'd0);
            chk($sformatf("lat3 c%0d mul_we", c), {63'd0, we3}, 64'd0);
            next_cycle();
        end
        sample();
        chk("lat3 c4 busy", {63'd0, busy3}, 64'd0);
        chk("lat3 c4 lo", {32'd0, lo3}, 64'd42);
        chk("lat3 c4 hi", {32'd0, hi3}, 64'd0);
        chk("lat3 c4 mul_done", {63'd0, done3}, 64'd1);
        next_cycle();

        // asynchronous reset in the middle of WAIT
        do_reset();
        mt_we = 1'b1;
        mt_sel = 1'b1;
        mt_data = 32'hCAFEF00D;
        next_cycle();
        idle_inputs();
        op_a = 32'd5;
        op_b = 32'd5;
        mul_start = 1'b1;
        next_cycle();
        mul_start = 1'b0;
        #2;
        chk("arst pre busy", {63'd0, busy1}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst busy", {63'd0, busy1}, 64'd0);
        chk("arst hi", {32'd0, hi1}, 64'd0);
        chk("arst lo", {32'd0, lo1}, 64'd0);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            sample();
            chk($sformatf("arst post%0d lo", c), {32'd0, lo1}, 64'd0);
            chk($sformatf("arst post%0d mul_done", c), {63'd0, done1}, 64'd0);
        end
        next_cycle();

        // same-cycle move-to LO and multiply, then a second held multiply
        mt_we = 1'b1;
        mt_sel = 1'b1;
        mt_data = 32'hAAAA5555;
        next_cycle();
        op_a = 32'd3;
        op_b = 32'd3;
        mt_sel = 1'b0;
        mt_data = 32'h12345678;
        mul_start = 1'b1;
        sample();
        chk("both c0 mul_we", {63'd0, we1}, 64'd1);
        chk("both c0 stall", {63'd0, stall1}, 64'd0);
        next_cycle();
        mt_we = 1'b0;
        sample();
        chk("both c1 lo", {32'd0, lo1}, 64'h12345678);
        chk("both c1 hi", {32'd0, hi1}, 64'hAAAA5555);
        chk("both c1 stall", {63'd0, stall1}, 64'd1);
        chk("both c1 mul_we", {63'd0, we1}, 64'd0);
        next_cycle();
        op_a = 32'd4;
        op_b = 32'd4;
        sample();
        chk("both c2 lo", {32'd0, lo1}, 64'd9);
        chk("both c2 hi", {32'd0, hi1}, 64'd0);
        chk("both c2 mul_done", {63'd0, done1}, 64'd1);
        chk("both c2 mul_we", {63'd0, we1}, 64'd1);
        next_cycle();
        mul_start = 1'b0;
        sample();
        chk("both c3 busy", {63'd0, busy1}, 64'd1);
        next_cycle();
        sample();
        chk("both c4 lo", {32'd0, lo1}, 64'd16);
        chk("both c4 mul_done", {63'd0, done1}, 64'd1);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // hard stop in case the sequence above ever stalls
    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
